riscv_run_ctrl: RTL and testbench

//  Parametrised run-control block for the riscv32i test harness. It sits between the GPIO control

---
 rtl/riscv_run_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_riscv_run_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_run_ctrl.sv
// riscv_run_ctrl: run sequencer for the riscv32i test harness.
// Watches rising edges of the GPIO control word, gates the core through
// RUN and DRAIN, counts RUN cycles and classifies how the run ended.
// Optional feature: define RUN_CTRL_WATCHDOG_EN to enable the RUN-cycle
// watchdog that ends a hung run with status TIMEOUT.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | core gated off, waiting for a start edge
//   RUN   | core enabled, cycle counter running, end-of-run detection
//   DRAIN | core still enabled for DRAIN_CYCLES, counter frozen
//   DONE  | core gated off, stop_sim_o high, results held
module riscv_run_ctrl #(
  parameter int unsigned          NUM_HARTS      = 1,
  parameter logic [NUM_HARTS-1:0] HART_MASK      = {NUM_HARTS{1'b1}},
  parameter int unsigned          CNT_W          = 32,
  parameter int unsigned          DRAIN_CYCLES   = 30,
  parameter int unsigned          TIMEOUT_CYCLES = 100000,
  parameter int unsigned          RST_PULSE      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          ctrl_i,
  input  logic [31:0]          success_code_i,
  input  logic [NUM_HARTS-1:0] finished_i,
  input  logic [NUM_HARTS-1:0] fail_i,
  output logic                 core_en_o,
  output logic                 core_rst_n_o,
  output logic                 stop_sim_o,
  output logic                 done_o,
  output logic [2:0]           status_o,
  output logic [1:0]           state_o,
  output logic [CNT_W-1:0]     cycle_count_o,
  output logic [31:0]          result_code_o
);

  localparam int unsigned       DW         = $clog2(DRAIN_CYCLES + 1);
  localparam int unsigned       RW         = $clog2(RST_PULSE + 1);
  localparam logic [DW-1:0]     DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
  localparam logic [RW-1:0]     RST_LOAD   = RW'(RST_PULSE);
  localparam logic [CNT_W-1:0]  TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
`ifdef RUN_CTRL_WATCHDOG_EN
  localparam bit                WDOG_EN    = 1'b1;
`else
  localparam bit                WDOG_EN    = 1'b0;
`endif

  localparam logic [2:0] ST_NONE  = 3'd0;
  localparam logic [2:0] ST_PASS  = 3'd1;
  localparam logic [2:0] ST_FAIL  = 3'd2;
  localparam logic [2:0] ST_TMO   = 3'd3;
  localparam logic [2:0] ST_ABORT = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [31:0]            ctrl_q;
  logic [31:0]            ev;
  logic [CNT_W-1:0]       cycle_cnt_q, cycle_cnt_d;
  logic [DW-1:0]          drain_cnt_q, drain_cnt_d;
  logic [2:0]             status_q, status_d;
  logic [31:0]            result_q, result_d;
  logic [NUM_HARTS-1:0]   fin_seen_q, fin_seen_d;
  logic [RW-1:0]          rst_cnt_q, rst_cnt_d;
  logic                   done_q, done_d;
  logic                   fin_all;
  logic                   wdog_hit;
  logic                   unused_ev;

  assign ev        = ctrl_i & ~ctrl_q;
  assign unused_ev = ^{ev[31:4], ev[1]};
  // Pulse finishes count from earlier cycles as well as the current one.
  assign fin_all   = ((fin_seen_q | finished_i) & HART_MASK) == HART_MASK;
  assign wdog_hit  = WDOG_EN && (cycle_cnt_q == TMO_LAST);

  // State and datapath registers; the reset counter starts at 1 so the core
  // reset releases on the first edge after rst_n deasserts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ctrl_q      <= '0;
      cycle_cnt_q <= '0;
      drain_cnt_q <= '0;
      status_q    <= ST_NONE;
      result_q    <= '0;
      fin_seen_q  <= '0;
      rst_cnt_q   <= RW'(1);
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_i;
      cycle_cnt_q <= cycle_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      status_q    <= status_d;
      result_q    <= result_d;
      fin_seen_q  <= fin_seen_d;
      rst_cnt_q   <= rst_cnt_d;
      done_q      <= done_d;
    end
  end

  // Next-state and datapath update, soft reset first then per-state events.
  always_comb begin
    state_d     = state_q;
    cycle_cnt_d = cycle_cnt_q;
    drain_cnt_d = drain_cnt_q;
    status_d    = status_q;
    result_d    = result_q;
    fin_seen_d  = fin_seen_q;
    rst_cnt_d   = (rst_cnt_q != '0) ? rst_cnt_q - 1'b1 : rst_cnt_q;

    if (ev[2]) begin
      state_d     = S_IDLE;
      cycle_cnt_d = '0;
      drain_cnt_d = '0;
      status_d    = ST_NONE;
      result_d    = '0;
      fin_seen_d  = '0;
      rst_cnt_d   = RST_LOAD;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (ev[0]) begin
            state_d     = S_RUN;
            cycle_cnt_d = '0;
            fin_seen_d  = '0;
            status_d    = ST_NONE;
            result_d    = '0;
          end
        end
        S_RUN: begin
          fin_seen_d = fin_seen_q | finished_i;
          // Counter freezes on the exit edge so it reports the detection cycle.
          if (ev[3]) begin
            state_d  = S_DONE;
            status_d = ST_ABORT;
          end else if (|fail_i) begin
            state_d     = S_DRAIN;
            status_d    = ST_FAIL;
            drain_cnt_d = DRAIN_LAST;
          end else if (fin_all) begin
            state_d     = S_DRAIN;
            status_d    = ST_PASS;
            result_d    = success_code_i;
            drain_cnt_d = DRAIN_LAST;
          end else if (wdog_hit) begin
            state_d     = S_DRAIN;
            status_d    = ST_TMO;
            drain_cnt_d = DRAIN_LAST;
          end else if (cycle_cnt_q != '1) begin
            cycle_cnt_d = cycle_cnt_q + 1'b1;
          end
        end
        S_DRAIN: begin
          if (ev[3]) begin
            state_d = S_DONE;
          end else begin
            if ((|fail_i) && (status_q == ST_PASS)) begin
              status_d = ST_FAIL;
              result_d = '0;
            end
            if (drain_cnt_q == '0) begin
              state_d = S_DONE;
            end else begin
              drain_cnt_d = drain_cnt_q - 1'b1;
            end
          end
        end
      endcase
    end

    done_d = (state_d == S_DONE) && (state_q != S_DONE);
  end

  assign core_en_o     = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign core_rst_n_o  = (rst_cnt_q == '0);
  assign stop_sim_o    = (state_q == S_DONE);
  assign done_o        = done_q;
  assign status_o      = status_q;
  assign state_o       = state_q;
  assign cycle_count_o = cycle_cnt_q;
  assign result_code_o = result_q;

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Bench for riscv_run_ctrl: two harts, both required for PASS, 30 drain
// cycles, 4-cycle core reset pulse. Each run's expected outcome is queued
// when the terminating stimulus is driven and popped on done_o.
module tb_riscv_run_ctrl;

  localparam int NH       = 2;
  localparam int S_IDLE   = 0;
  localparam int S_RUN    = 1;
  localparam int S_DRAIN  = 2;
  localparam int S_DONE   = 3;
  localparam int ST_NONE  = 0;
  localparam int ST_PASS  = 1;
  localparam int ST_FAIL  = 2;
  localparam int ST_TMO   = 3;
  localparam int ST_ABORT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   ctrl_i;
  logic [31:0]   success_code_i;
  logic [NH-1:0] finished_i;
  logic [NH-1:0] fail_i;
  logic          core_en_o;
  logic          core_rst_n_o;
  logic          stop_sim_o;
  logic          done_o;
  logic [2:0]    status_o;
  logic [1:0]    state_o;
  logic [31:0]   cycle_count_o;
  logic [31:0]   result_code_o;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] status;
    logic [31:0] count;
    logic [31:0] result;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  riscv_run_ctrl #(
    .NUM_HARTS(NH), .HART_MASK(2'b11), .CNT_W(32), .DRAIN_CYCLES(30),
    .TIMEOUT_CYCLES(200), .RST_PULSE(4)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .ctrl_i(ctrl_i), .success_code_i(success_code_i),
    .finished_i(finished_i), .fail_i(fail_i), .core_en_o(core_en_o),
    .core_rst_n_o(core_rst_n_o), .stop_sim_o(stop_sim_o), .done_o(done_o),
    .status_o(status_o), .state_o(state_o), .cycle_count_o(cycle_count_o),
    .result_code_o(result_code_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input logic [31:0] st, input logic [31:0] cnt, input logic [31:0] res);
    exp_t e;
    e.status = st;
    e.count  = cnt;
    e.result = res;
    sb_q.push_back(e);
  endtask

  task automatic start_run(input string tag);
    ctrl_i[0] = 1'b1;
    step(1);
    ctrl_i[0] = 1'b0;
    check_eq({tag, "_start_state"}, 32'(state_o), S_RUN);
    check_eq({tag, "_start_count"}, cycle_count_o, 0);
    check_eq({tag, "_start_status"}, 32'(status_o), ST_NONE);
    check_eq({tag, "_start_stop"}, 32'(stop_sim_o), 0);
  endtask

  // Scoreboard consumer: one expected record per done_o pulse.
  always @(posedge clk) begin
    #1;
    if (rst_n === 1'b1 && done_o === 1'b1) begin
      check_eq("done_stop", 32'(stop_sim_o), 1);
      check_eq("done_core_en", 32'(core_en_o), 0);
      if (sb_q.size() == 0) begin
        check_eq("sb_underflow", sb_q.size(), 1);
      end else begin : pop_blk
        exp_t e;
        e = sb_q.pop_front();
        check_eq("sb_status", 32'(status_o), e.status);
        check_eq("sb_count", cycle_count_o, e.count);
        check_eq("sb_result", result_code_o, e.result);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: bench did not reach its end");
    $fatal(1, "bench time limit exceeded");
  end

  initial begin
    rst_n          = 1'b0;
    ctrl_i         = '0;
    success_code_i = '0;
    finished_i     = '0;
    fail_i         = '0;
    step(3);
    check_eq("rst_state", 32'(state_o), S_IDLE);
    check_eq("rst_core_rst_n", 32'(core_rst_n_o), 0);
    check_eq("rst_core_en", 32'(core_en_o), 0);
    check_eq("rst_stop", 32'(stop_sim_o), 0);
    check_eq("rst_done", 32'(done_o), 0);
    check_eq("rst_status", 32'(status_o), ST_NONE);
    check_eq("rst_count", cycle_count_o, 0);
    check_eq("rst_result", result_code_o, 0);
    rst_n = 1'b1;
    step(1);
    check_eq("rst_release_core_rst_n", 32'(core_rst_n_o), 1);
    check_eq("rst_release_state", 32'(state_o), S_IDLE);

    // Both harts finish together at RUN cycle 50.
    success_code_i = 32'h600D;
    start_run("t1");
    step(50);
    check_eq("t1_count_before", cycle_count_o, 50);
    finished_i = 2'b11;
    push_exp(ST_PASS, 50, 32'h600D);
    step(1);
    finished_i = '0;
    check_eq("t1_state", 32'(state_o), S_DRAIN);
    check_eq("t1_status", 32'(status_o), ST_PASS);
    check_eq("t1_result", result_code_o, 32'h600D);
    check_eq("t1_count", cycle_count_o, 50);
    check_eq("t1_core_en", 32'(core_en_o), 1);
    step(29);
    check_eq("t1_stop_early", 32'(stop_sim_o), 0);
    check_eq("t1_still_drain", 32'(state_o), S_DRAIN);
    step(1);
    check_eq("t1_stop", 32'(stop_sim_o), 1);
    check_eq("t1_done", 32'(done_o), 1);
    check_eq("t1_state_done", 32'(state_o), S_DONE);
    step(1);
    check_eq("t1_done_single", 32'(done_o), 0);
    check_eq("t1_stop_held", 32'(stop_sim_o), 1);
    check_eq("t1_count_held", cycle_count_o, 50);

    // Harts finish at different times; a start edge mid-run is ignored.
    success_code_i = 32'h1234_5678;
    start_run("t2");
    step(10);
    finished_i = 2'b01;
    step(1);
    finished_i = '0;
    check_eq("t2_partial_run", 32'(state_o), S_RUN);
    check_eq("t2_partial_count", cycle_count_o, 11);
    ctrl_i[0] = 1'b1;
    step(1);
    ctrl_i[0] = 1'b0;
    step(28);
    check_eq("t2_count_before", cycle_count_o, 40);
    finished_i = 2'b10;
    push_exp(ST_PASS, 40, 32'h1234_5678);
    step(1);
    finished_i = '0;
    check_eq("t2_state", 32'(state_o), S_DRAIN);
    check_eq("t2_status", 32'(status_o), ST_PASS);
    check_eq("t2_count", cycle_count_o, 40);
    step(30);
    check_eq("t2_done_state", 32'(state_o), S_DONE);

    // Fail and full finish in the same cycle.
    start_run("t3");
    step(5);
    finished_i = 2'b11;
    fail_i     = 2'b10;
    push_exp(ST_FAIL, 5, 0);
    step(1);
    finished_i = '0;
    fail_i     = '0;
    check_eq("t3_status", 32'(status_o), ST_FAIL);
    check_eq("t3_result", result_code_o, 0);
    check_eq("t3_count", cycle_count_o, 5);
    check_eq("t3_state", 32'(state_o), S_DRAIN);
    step(30);
    check_eq("t3_done_state", 32'(state_o), S_DONE);

    // PASS upgraded to FAIL during drain; drain length unchanged.
    start_run("t3b");
    step(7);
    finished_i = 2'b11;
    push_exp(ST_FAIL, 7, 0);
    step(1);
    finished_i = '0;
    check_eq("t3b_pass", 32'(status_o), ST_PASS);
    check_eq("t3b_pass_result", result_code_o, 32'h1234_5678);
    step(10);
    fail_i = 2'b01;
    step(1);
    fail_i = '0;
    check_eq("t3b_upgrade", 32'(status_o), ST_FAIL);
    check_eq("t3b_result_cleared", result_code_o, 0);
    check_eq("t3b_state", 32'(state_o), S_DRAIN);
    step(18);
    check_eq("t3b_stop_early", 32'(stop_sim_o), 0);
    step(1);
    check_eq("t3b_stop", 32'(stop_sim_o), 1);

    // Abort in RUN skips drain.
    start_run("t5");
    step(20);
    ctrl_i[3] = 1'b1;
    push_exp(ST_ABORT, 20, 0);
    step(1);
    ctrl_i[3] = 1'b0;
    check_eq("t5_state", 32'(state_o), S_DONE);
    check_eq("t5_status", 32'(status_o), ST_ABORT);
    check_eq("t5_core_en", 32'(core_en_o), 0);
    check_eq("t5_count", cycle_count_o, 20);
    check_eq("t5_done", 32'(done_o), 1);
    step(1);
    check_eq("t5_done_single", 32'(done_o), 0);

    // Abort in DRAIN keeps the PASS status.
    start_run("t5b");
    step(3);
    finished_i = 2'b11;
    push_exp(ST_PASS, 3, 32'h1234_5678);
    step(1);
    finished_i = '0;
    step(5);
    ctrl_i[3] = 1'b1;
    step(1);
    ctrl_i[3] = 1'b0;
    check_eq("t5b_state", 32'(state_o), S_DONE);
    check_eq("t5b_status", 32'(status_o), ST_PASS);
    check_eq("t5b_result", result_code_o, 32'h1234_5678);

    // Hung program: watchdog or stays in RUN.
    start_run("t4");
`ifdef RUN_CTRL_WATCHDOG_EN
    step(199);
    check_eq("t4_state_before", 32'(state_o), S_RUN);
    push_exp(ST_TMO, 199, 0);
    step(1);
    check_eq("t4_state", 32'(state_o), S_DRAIN);
    check_eq("t4_status", 32'(status_o), ST_TMO);
    check_eq("t4_count", cycle_count_o, 199);
    step(30);
    check_eq("t4_done_state", 32'(state_o), S_DONE);
`else
    step(10000);
    check_eq("t4_still_run", 32'(state_o), S_RUN);
    check_eq("t4_status", 32'(status_o), ST_NONE);
    check_eq("t4_count", cycle_count_o, 10000);
    ctrl_i[3] = 1'b1;
    push_exp(ST_ABORT, 10000, 0);
    step(1);
    ctrl_i[3] = 1'b0;
    check_eq("t4_abort_state", 32'(state_o), S_DONE);
    check_eq("t4_abort_status", 32'(status_o), ST_ABORT);
`endif

    // Soft reset during DRAIN with start held high.
    ctrl_i[0] = 1'b1;
    step(1);
    check_eq("t6_run", 32'(state_o), S_RUN);
    step(4);
    finished_i = 2'b11;
    step(1);
    finished_i = '0;
    check_eq("t6_drain", 32'(state_o), S_DRAIN);
    step(3);
    ctrl_i[2] = 1'b1;
    step(1);
    check_eq("t6_state", 32'(state_o), S_IDLE);
    check_eq("t6_core_rst_n", 32'(core_rst_n_o), 0);
    check_eq("t6_status", 32'(status_o), ST_NONE);
    check_eq("t6_count", cycle_count_o, 0);
    check_eq("t6_result", result_code_o, 0);
    check_eq("t6_core_en", 32'(core_en_o), 0);
    check_eq("t6_stop", 32'(stop_sim_o), 0);
    check_eq("t6_done", 32'(done_o), 0);
    step(3);
    check_eq("t6_pulse_last_low", 32'(core_rst_n_o), 0);
    step(1);
    check_eq("t6_pulse_end", 32'(core_rst_n_o), 1);
    check_eq("t6_no_restart", 32'(state_o), S_IDLE);
    ctrl_i[2] = 1'b0;
    step(1);
    ctrl_i[2] = 1'b1;
    step(1);
    ctrl_i[2] = 1'b0;
    step(1);
    ctrl_i[2] = 1'b1;
    step(1);
    ctrl_i[2] = 1'b0;
    check_eq("t6_pulse2_low", 32'(core_rst_n_o), 0);
    step(2);
    check_eq("t6_pulse_restart", 32'(core_rst_n_o), 0);
    step(1);
    check_eq("t6_pulse_restart_last", 32'(core_rst_n_o), 0);
    step(1);
    check_eq("t6_pulse_restart_end", 32'(core_rst_n_o), 1);
    check_eq("t6_idle_held", 32'(state_o), S_IDLE);
    ctrl_i[0] = 1'b0;
    step(1);
    check_eq("t6_idle_low", 32'(state_o), S_IDLE);
    ctrl_i[0] = 1'b1;
    step(1);
    check_eq("t6_new_edge_run", 32'(state_o), S_RUN);
    ctrl_i[3] = 1'b1;
    push_exp(ST_ABORT, 0, 0);
    step(1);
    ctrl_i[3] = 1'b0;
    ctrl_i[0] = 1'b0;
    check_eq("t6_abort_state", 32'(state_o), S_DONE);

    step(2);
    check_eq("sb_leftover", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
